// File: rtl/auv_pkg.sv
// Shared types for the AUV writeback path: register address, data word and writeback request.
package auv_pkg;
  localparam int NUM_REGS = 16;

  typedef logic [3:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t wa;
    word_t     wd;
  } wb_req_t;
endpackage

// File: rtl/auv_wb_fifo.sv
// Load-result FIFO holding wb_req_t entries; DEPTH need not be a power of two.
// Caller must only push when !full and only pop when !empty.
module auv_wb_fifo
  import auv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_dat,
  input  logic    pop,
  output wb_req_t pop_dat,
  output logic    full,
  output logic    empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: count and pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_dat;
  end

  assign pop_dat = r_mem[r_rd_ptr];
  assign full    = (r_cnt == CW'(DEPTH));
  assign empty   = (r_cnt == '0);
endmodule

// File: rtl/auv_wb_ctrl.sv
// Writeback controller: ALU/LSU arbitration onto one register-file write port plus pending-write scoreboard.
// Define AUV_WB_FWD_EN to exclude a source being written this cycle from the hazard stall.
module auv_wb_ctrl
  import auv_pkg::*;
#(
  parameter int LSU_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  input  logic [3:0]          iss_wa,
  input  logic                alu_valid,
  input  logic [3:0]          alu_wa,
  input  logic [31:0]         alu_wd,
  input  logic                lsu_valid,
  input  logic [3:0]          lsu_wa,
  input  logic [31:0]         lsu_wd,
  output logic                lsu_ready,
  input  logic [3:0]          ra0,
  input  logic [3:0]          ra1,
  output logic                hz_stall,
  output logic                we,
  output logic [3:0]          wa,
  output logic [31:0]         wd,
  output logic [NUM_REGS-1:0] busy
);
  logic                r_we;
  reg_addr_t           r_wa;
  word_t               r_wd;
  logic [NUM_REGS-1:0] r_busy;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  wb_req_t             w_lsu_req;
  wb_req_t             w_head;
  wb_req_t             w_res;
  logic                w_res_vld;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_fwd0;
  logic                w_fwd1;

  assign w_lsu_req = '{wa: lsu_wa, wd: lsu_wd};
  assign lsu_ready = ~w_full;
  assign w_push    = lsu_valid & ~w_full;
  assign w_pop     = ~alu_valid & ~w_empty;

  auv_wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_dat (w_lsu_req),
    .pop      (w_pop),
    .pop_dat  (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // ALU has strict priority; the FIFO head only drains in ALU-idle cycles.
  always_comb begin
    w_res_vld = alu_valid | ~w_empty;
    w_res     = alu_valid ? '{wa: alu_wa, wd: alu_wd} : w_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_res_vld & (w_res.wa != '0);
      if (w_res_vld) begin
        r_wa <= w_res.wa;
        r_wd <= w_res.wd;
      end
    end
  end

  // Clear before set so a same-edge issue of the register keeps it pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) w_busy_nxt[r_wa] = 1'b0;
    if (iss_valid && (iss_wa != '0)) w_busy_nxt[iss_wa] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

`ifdef AUV_WB_FWD_EN
  assign w_fwd0 = r_we & (r_wa == ra0);
  assign w_fwd1 = r_we & (r_wa == ra1);
`else
  assign w_fwd0 = 1'b0;
  assign w_fwd1 = 1'b0;
`endif

  assign hz_stall = (r_busy[ra0] & ~w_fwd0) | (r_busy[ra1] & ~w_fwd1);

  assign we   = r_we;
  assign wa   = r_wa;
  assign wd   = r_wd;
  assign busy = r_busy;
endmodule

// File: tb/tb_auv_wb_ctrl.sv
// Bench for auv_wb_ctrl: directed scenarios and random traffic against a queue-based reference model.
module tb_auv_wb_ctrl;
  import auv_pkg::*;

  localparam int DEPTH = 2;
`ifdef AUV_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, alu_valid, lsu_valid, lsu_ready, hz_stall, we;
  logic [3:0]  iss_wa, alu_wa, lsu_wa, ra0, ra1, wa;
  logic [31:0] alu_wd, lsu_wd, wd;
  logic [15:0] busy;

  auv_wb_ctrl #(.LSU_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_wa(iss_wa),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .ra0(ra0), .ra1(ra1), .hz_stall(hz_stall),
    .we(we), .wa(wa), .wd(wd), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending loads in order, pending-write set, last write-port state.
  wb_req_t     m_q[$];
  logic [15:0] m_busy;
  logic        m_we;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_track;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy  = '0;
    m_we    = 1'b0;
    m_wa    = '0;
    m_wd    = '0;
    m_track = 1'b1;
  endtask

  task automatic step(input logic iv, input logic [3:0] iwa,
                      input logic av, input logic [3:0] awa, input logic [31:0] awd,
                      input logic lv, input logic [3:0] lwa, input logic [31:0] lwd,
                      input logic [3:0] r0, input logic [3:0] r1);
    bit          rdy, hz, got;
    wb_req_t     res;
    logic [15:0] nb;
    @(negedge clk);
    chk("we", we, m_we);
    if (m_track) begin
      chk("wa", wa, m_wa);
      chk("wd", wd, m_wd);
    end
    chk("busy", busy, m_busy);
    iss_valid = iv; iss_wa = iwa;
    alu_valid = av; alu_wa = awa; alu_wd = awd;
    lsu_valid = lv; lsu_wa = lwa; lsu_wd = lwd;
    ra0 = r0; ra1 = r1;
    #1;
    rdy = (m_q.size() < DEPTH);
    hz  = (m_busy[r0] && !(FWD && m_we && m_wa == r0)) ||
          (m_busy[r1] && !(FWD && m_we && m_wa == r1));
    chk("lsu_ready", lsu_ready, rdy);
    chk("hz_stall", hz_stall, hz);
    got = 1'b0;
    res = '0;
    if (av) begin
      got = 1'b1; res = '{wa: awa, wd: awd};
    end else if (m_q.size() > 0) begin
      got = 1'b1; res = m_q.pop_front();
    end
    if (lv && rdy) m_q.push_back('{wa: lwa, wd: lwd});
    nb = m_busy;
    if (m_we) nb[m_wa] = 1'b0;
    if (iv && iwa != 0) nb[iwa] = 1'b1;
    nb[0]  = 1'b0;
    m_busy = nb;
    m_we   = got && res.wa != 0;
    if (got) begin
      m_wa    = res.wa;
      m_wd    = res.wd;
      m_track = (res.wa != 0);
    end
  endtask

  task automatic idle(input logic [3:0] r0 = 4'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, r0, 0);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    iss_valid = 0; alu_valid = 0; lsu_valid = 0;
    #1;
    chk("rst_we", we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_hz_stall", hz_stall, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int we_cnt;
    rst_n = 1'b0;
    iss_valid = 0; iss_wa = 0; alu_valid = 0; alu_wa = 0; alu_wd = 0;
    lsu_valid = 0; lsu_wa = 0; lsu_wd = 0; ra0 = 0; ra1 = 0;
    apply_reset();

    // Issue r5 then ALU write of r5.
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    post_edge();
    chk("r5_we", we, 1);
    chk("r5_wa", wa, 5);
    chk("r5_wd", wd, 32'hDEADBEEF);
    chk("r5_busy_held", busy[5], 1);
    idle();
    post_edge();
    chk("r5_busy_clr", busy[5], 0);

    // ALU and LSU in the same cycle: ALU first, LSU next.
    step(0, 0, 1, 3, 32'h0000_3333, 1, 7, 32'h0000_7777, 0, 0);
    post_edge();
    chk("dual_first_wa", wa, 3);
    idle();
    post_edge();
    chk("dual_second_we", we, 1);
    chk("dual_second_wa", wa, 7);
    chk("dual_second_wd", wd, 32'h0000_7777);

    // Four ALU cycles with LSU pushes: FIFO fills and back-pressures.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 4'(1 + i), 32'(i), 1, 4'(8 + (i < 2 ? i : 2)), 32'h100 + 32'(i), 0, 0);
      if (i >= 2) chk("fill_ready", lsu_ready, 0);
    end
    idle();
    post_edge();
    chk("drain0_wa", wa, 8);
    idle();
    post_edge();
    chk("drain1_wa", wa, 9);
    idle();

    // Hazard during write of r4, then r0 behaviour.
    step(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 32'h4444, 0, 0, 0, 4, 0);
    idle(4);
    chk("r4_hz", hz_stall, FWD ? 0 : 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'hABCD, 0, 0, 0, 0, 0);
    post_edge();
    chk("wa0_we", we, 0);
    chk("iss0_busy", busy, 0);

    // Reset mid-operation with two queued loads and busy=0x00F0.
    step(1, 4, 1, 1, 1, 1, 9, 32'h99, 0, 0);
    step(1, 5, 1, 1, 2, 1, 10, 32'hAA, 0, 0);
    step(1, 6, 1, 1, 3, 0, 0, 0, 0, 0);
    step(1, 7, 1, 1, 4, 0, 0, 0, 0, 0);
    post_edge();
    chk("pre_rst_busy", busy, 16'h00F0);
    chk("pre_rst_full", lsu_ready, 0);
    apply_reset();
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      post_edge();
      we_cnt += int'(we);
    end
    chk("post_rst_no_write", 32'(we_cnt), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (i == 200) apply_reset();
    end
    repeat (4) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
